// File: rtl/arb_v.sv
// Two-master bus arbiter (DMA / TDSP) with one-hot registered grants and optional hold-limit preemption.
// Build option: define ARB_RR_EN to alternate the IDLE tie-break instead of fixed TDSP priority.
module arb_v #(
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic reset,
  input  logic clk,
  input  logic dma_breq,
  output logic dma_grant,
  input  logic tdsp_breq,
  output logic tdsp_grant
);

  // state    | meaning
  // IDLE     | bus free; both grants low (also the turnaround cycle between owners)
  // GNT_DMA  | DMA engine owns the bus
  // GNT_TDSP | TDSP core owns the bus
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_DMA  = 2'd1,
    GNT_TDSP = 2'd2
  } state_t;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_SAT   = 8'd255;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic       force_rel;
  logic       force_rel_nxt;
  logic       last_dma;
  logic       last_dma_nxt;
  logic       tie_dma;
  logic       own_req;
  logic       other_req;

`ifdef ARB_RR_EN
  assign tie_dma = ~last_dma;
`else
  assign tie_dma = 1'b0;
`endif

  assign own_req   = (state == GNT_DMA) ? dma_breq : tdsp_breq;
  assign other_req = (state == GNT_DMA) ? tdsp_breq : dma_breq;

  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    force_rel_nxt = force_rel;
    last_dma_nxt  = last_dma;
    case (state)
      IDLE: begin
        force_rel_nxt = 1'b0;
        hold_cnt_nxt  = 8'd0;
        // a forced release hands the bus to the side that was waiting, once
        if (force_rel && last_dma && tdsp_breq)
          state_nxt = GNT_TDSP;
        else if (force_rel && !last_dma && dma_breq)
          state_nxt = GNT_DMA;
        else if (tdsp_breq && dma_breq)
          state_nxt = tie_dma ? GNT_DMA : GNT_TDSP;
        else if (tdsp_breq)
          state_nxt = GNT_TDSP;
        else if (dma_breq)
          state_nxt = GNT_DMA;
        else
          state_nxt = IDLE;

        if (state_nxt == GNT_DMA)
          last_dma_nxt = 1'b1;
        else if (state_nxt == GNT_TDSP)
          last_dma_nxt = 1'b0;
      end
      GNT_DMA, GNT_TDSP: begin
        if (other_req) begin
          if (PREEMPT_EN && (hold_cnt == HOLD_LAST)) begin
            state_nxt     = IDLE;
            force_rel_nxt = 1'b1;
            hold_cnt_nxt  = 8'd0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
          end
        end
        if ((state_nxt != IDLE) && !own_req) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = 8'd0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        hold_cnt_nxt  = 8'd0;
        force_rel_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= 8'd0;
      force_rel  <= 1'b0;
      last_dma   <= 1'b1;
      dma_grant  <= 1'b0;
      tdsp_grant <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      force_rel  <= force_rel_nxt;
      last_dma   <= last_dma_nxt;
      dma_grant  <= (state_nxt == GNT_DMA);
      tdsp_grant <= (state_nxt == GNT_TDSP);
    end
  end

endmodule

// File: tb/tb_arb_v.sv
// Bench for arb_v: two instances (no preemption / MAX_HOLD=4) against an owner-level model,
// plus directed vectors with literal expected grants.
module tb_arb_v;

  logic clk;
  logic reset;
  logic dma_breq;
  logic tdsp_breq;
  logic dma_grant0, tdsp_grant0;
  logic dma_grant4, tdsp_grant4;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  arb_v #(.MAX_HOLD(0)) dut0 (
    .reset(reset), .clk(clk),
    .dma_breq(dma_breq), .dma_grant(dma_grant0),
    .tdsp_breq(tdsp_breq), .tdsp_grant(tdsp_grant0)
  );

  arb_v #(.MAX_HOLD(4)) dut4 (
    .reset(reset), .clk(clk),
    .dma_breq(dma_breq), .dma_grant(dma_grant4),
    .tdsp_breq(tdsp_breq), .tdsp_grant(tdsp_grant4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Owner-level model: 0 = nobody, 1 = DMA, 2 = TDSP.
  int m_own  [2];
  int m_cnt  [2];
  bit m_force[2];
  int m_last [2];
  int m_limit[2] = '{0, 4};

  function automatic int other(input int who);
    return (who == 1) ? 2 : 1;
  endfunction

  function automatic bit req_of(input int who, input bit d, input bit t);
    return (who == 1) ? d : t;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_own[i] = 0; m_cnt[i] = 0; m_force[i] = 0; m_last[i] = 1;
      end else if (m_own[i] == 0) begin
        int pick;
        pick = 0;
        if (m_force[i] && req_of(other(m_last[i]), dma_breq, tdsp_breq))
          pick = other(m_last[i]);
        else if (dma_breq && tdsp_breq) begin
`ifdef ARB_RR_EN
          pick = other(m_last[i]);
`else
          pick = 2;
`endif
        end
        else if (tdsp_breq) pick = 2;
        else if (dma_breq)  pick = 1;
        m_force[i] = 0;
        m_cnt[i]   = 0;
        if (pick != 0) m_last[i] = pick;
        m_own[i] = pick;
      end else begin
        bit contended;
        contended = req_of(other(m_own[i]), dma_breq, tdsp_breq);
        if (contended && m_cnt[i] < 255) m_cnt[i]++;
        if (contended && m_limit[i] != 0 && m_cnt[i] >= m_limit[i]) begin
          m_own[i] = 0; m_cnt[i] = 0; m_force[i] = 1;
        end else if (!req_of(m_own[i], dma_breq, tdsp_breq)) begin
          m_own[i] = 0; m_cnt[i] = 0;
        end
      end
    end
    started = 1;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("m0_dma",  dma_grant0,  m_own[0] == 1);
      check("m0_tdsp", tdsp_grant0, m_own[0] == 2);
      check("m4_dma",  dma_grant4,  m_own[1] == 1);
      check("m4_tdsp", tdsp_grant4, m_own[1] == 2);
      check("onehot0", dma_grant0 & tdsp_grant0, 1'b0);
      check("onehot4", dma_grant4 & tdsp_grant4, 1'b0);
    end
  end

  task automatic step(input bit r, input bit d, input bit t);
    reset = r; dma_breq = d; tdsp_breq = t;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic d0, input logic t0,
                     input logic d4, input logic t4);
    check({name, "_d0"}, dma_grant0,  d0);
    check({name, "_t0"}, tdsp_grant0, t0);
    check({name, "_d4"}, dma_grant4,  d4);
    check({name, "_t4"}, tdsp_grant4, t4);
  endtask

  initial begin
    reset = 1'b1; dma_breq = 1'b0; tdsp_breq = 1'b0;

    // reset overrides requests
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1);
      lit("rst", 0, 0, 0, 0);
    end
    step(0, 1, 1);  lit("first_gnt", 0, 1, 0, 1);
    step(0, 0, 0);  lit("rel1", 0, 0, 0, 0);

    // DMA alone
    step(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0);
      lit("dma_only", 1, 0, 1, 0);
    end
    step(0, 0, 0);  lit("dma_drop", 0, 0, 0, 0);

    // tie in IDLE, then handover via one idle cycle
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1);
      lit("tie", 0, 1, 0, 1);
    end
    step(0, 1, 0);  lit("tie_turn", 0, 0, 0, 0);
    step(0, 1, 0);  lit("tie_dma", 1, 0, 1, 0);
    step(0, 0, 0);  lit("idle2", 0, 0, 0, 0);

    // DMA owner contended by TDSP: dut4 preempts after 4 contended edges
    step(0, 1, 0);  lit("pre_dma", 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1);
      lit("cont", 1, 0, 1, 0);
    end
    step(0, 1, 1);  lit("preempt", 1, 0, 0, 0);
    step(0, 1, 1);  lit("forced_t", 1, 0, 0, 1);
    step(0, 0, 1);  lit("nopre_rel", 0, 0, 0, 1);
    step(0, 0, 1);  lit("nopre_t", 0, 1, 0, 1);

    // TDSP owner contended by DMA: forced release overrides TDSP priority
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1);
      lit("cont_t", 0, 1, 0, 1);
    end
    step(0, 1, 1);  lit("preempt_t", 0, 1, 0, 0);
    step(0, 1, 1);  lit("forced_d", 0, 1, 1, 0);

    // reset mid-grant drops it on that edge
    step(1, 1, 1);  lit("rst_mid", 0, 0, 0, 0);
    step(0, 0, 0);

`ifdef ARB_RR_EN
    // alternating ties under round-robin: TDSP, DMA, TDSP
    step(0, 1, 1); step(0, 1, 1);  lit("rr_t1", 0, 1, 0, 1);
    step(0, 1, 0);  lit("rr_gap1", 0, 0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);  lit("rr_d", 1, 0, 1, 0);
    step(0, 0, 1);  lit("rr_gap2", 0, 0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);  lit("rr_t2", 0, 1, 0, 1);
    step(0, 0, 0);
`endif

    // pseudo-random soak, compared against the model every cycle
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 2, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    step(0, 0, 0);
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
